// File: rtl/ones_counter_if.sv
// Occupancy-count bus: the sensor side drives a vector, the counter returns a
// registered count, full/saturated flags and a one-cycle result strobe.
interface ones_counter_if #(
  parameter int N_SPACES = 8,
  parameter int CNT_W    = 3
);
  // Valid-only handshake, no ready: the counter always accepts. new_capacity
  // is sampled on every edge with in_valid=1. out_valid pulses for exactly
  // one cycle per accepted vector, and the results hold between pulses.
  logic [N_SPACES-1:0] new_capacity;
  logic                in_valid;
  logic [CNT_W-1:0]    parked;
  logic                all_occupied;
  logic                saturated;
  logic                out_valid;

  modport master (
    output new_capacity, in_valid,
    input  parked, all_occupied, saturated, out_valid
  );

  modport slave (
    input  new_capacity, in_valid,
    output parked, all_occupied, saturated, out_valid
  );
endinterface

// File: rtl/ones_counter.sv
// Registered population counter for parking occupancy: counts set bits,
// saturates the count at 2^CNT_W-1 and flags the all-occupied case.
module ones_counter #(
  parameter int N_SPACES = 8,
  parameter int CNT_W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  ones_counter_if.slave bus
);

  localparam int TW     = $clog2(N_SPACES + 1);
  localparam int LEVELS = $clog2(N_SPACES);
  localparam int P      = 1 << LEVELS;

  if (CNT_W < 1 || N_SPACES > 64 || N_SPACES < 2) begin : g_param_check
    $error("ones_counter: need CNT_W >= 1 and 2 <= N_SPACES <= 64");
  end

  // Binary adder tree: leaves are padded to a power of two, and each level
  // is one bit wider than the level below it.
  for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
    logic [lv:0] s [P >> lv];
    for (genvar j = 0; j < (P >> lv); j++) begin : g_node
      if (lv == 0) begin : g_leaf
        if (j < N_SPACES) begin : g_bit
          assign s[j] = bus.new_capacity[j];
        end else begin : g_pad
          assign s[j] = 1'b0;
        end
      end else begin : g_sum
        assign s[j] = {1'b0, g_lvl[lv-1].s[2*j]} + {1'b0, g_lvl[lv-1].s[2*j+1]};
      end
    end
  end

  logic [LEVELS:0]  tree_root;
  logic [TW-1:0]    true_cnt;
  logic [CNT_W-1:0] parked_d,   parked_q;
  logic             saturated_d, saturated_q;
  logic             all_occ_d,  all_occ_q;
  logic             out_valid_q;

  assign tree_root = g_lvl[LEVELS].s[0];
  assign true_cnt  = tree_root[TW-1:0];
  assign all_occ_d = (true_cnt == TW'(N_SPACES));

  if (CNT_W >= TW) begin : g_no_sat
    assign saturated_d = 1'b0;
    assign parked_d    = CNT_W'(true_cnt);
  end else begin : g_sat
    // Any set bit above the count width means C exceeds 2^CNT_W-1.
    assign saturated_d = |true_cnt[TW-1:CNT_W];
    assign parked_d    = saturated_d ? {CNT_W{1'b1}} : true_cnt[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parked_q    <= '0;
      saturated_q <= 1'b0;
      all_occ_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        parked_q    <= parked_d;
        saturated_q <= saturated_d;
        all_occ_q   <= all_occ_d;
      end
    end
  end

  assign bus.parked       = parked_q;
  assign bus.saturated    = saturated_q;
  assign bus.all_occupied = all_occ_q;
  assign bus.out_valid    = out_valid_q;

endmodule

// File: tb/tb_ones_counter.sv
// Directed bench for ones_counter (N_SPACES=8, CNT_W=3) with a final
// popcount-model random sweep.
module tb_ones_counter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ones_counter_if #(.N_SPACES(8), .CNT_W(3)) bus ();

  ones_counter #(.N_SPACES(8), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.new_capacity = 8'h00;
    step();
    step();
    checks++; if (bus.parked !== 3'd0) begin failures++; $display("FAIL reset_parked got=%0d exp=0", bus.parked); end
    checks++; if (bus.all_occupied !== 1'b0) begin failures++; $display("FAIL reset_all got=%b exp=0", bus.all_occupied); end
    checks++; if (bus.saturated !== 1'b0) begin failures++; $display("FAIL reset_sat got=%b exp=0", bus.saturated); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_ov got=%b exp=0", bus.out_valid); end
    rst = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_ov got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_single();
    bus.new_capacity = 8'b1111_0000;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.parked !== 3'd4) begin failures++; $display("FAIL single_parked got=%0d exp=4", bus.parked); end
    checks++; if (bus.all_occupied !== 1'b0) begin failures++; $display("FAIL single_all got=%b exp=0", bus.all_occupied); end
    checks++; if (bus.saturated !== 1'b0) begin failures++; $display("FAIL single_sat got=%b exp=0", bus.saturated); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_ov got=%b exp=1", bus.out_valid); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_ov_drop got=%b exp=0", bus.out_valid); end
    checks++; if (bus.parked !== 3'd4) begin failures++; $display("FAIL single_hold got=%0d exp=4", bus.parked); end
  endtask

  task automatic test_saturation();
    bus.new_capacity = 8'b1111_1111;
    bus.in_valid = 1'b1;
    step();
    checks++; if (bus.parked !== 3'd7) begin failures++; $display("FAIL full_parked got=%0d exp=7", bus.parked); end
    checks++; if (bus.all_occupied !== 1'b1) begin failures++; $display("FAIL full_all got=%b exp=1", bus.all_occupied); end
    checks++; if (bus.saturated !== 1'b1) begin failures++; $display("FAIL full_sat got=%b exp=1", bus.saturated); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL full_ov got=%b exp=1", bus.out_valid); end
    bus.new_capacity = 8'b0111_1111;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.parked !== 3'd7) begin failures++; $display("FAIL seven_parked got=%0d exp=7", bus.parked); end
    checks++; if (bus.all_occupied !== 1'b0) begin failures++; $display("FAIL seven_all got=%b exp=0", bus.all_occupied); end
    checks++; if (bus.saturated !== 1'b0) begin failures++; $display("FAIL seven_sat got=%b exp=0", bus.saturated); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [5];
    logic [2:0] exp [5];
    vec[0] = 8'b0000_0001; exp[0] = 3'd1;
    vec[1] = 8'b0001_0001; exp[1] = 3'd2;
    vec[2] = 8'b0011_0011; exp[2] = 3'd4;
    vec[3] = 8'b0101_1001; exp[3] = 3'd4;
    vec[4] = 8'b1010_1010; exp[4] = 3'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.new_capacity = vec[i];
      step();
      checks++; if (bus.parked !== exp[i]) begin failures++; $display("FAIL b2b_parked[%0d] got=%0d exp=%0d", i, bus.parked, exp[i]); end
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_ov[%0d] got=%b exp=1", i, bus.out_valid); end
      checks++; if ({bus.all_occupied, bus.saturated} !== 2'b00) begin failures++; $display("FAIL b2b_flags[%0d] got=%b exp=00", i, {bus.all_occupied, bus.saturated}); end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_hold();
    bus.new_capacity = 8'b0000_0000;
    bus.in_valid = 1'b1;
    step();
    checks++; if (bus.parked !== 3'd0) begin failures++; $display("FAIL zero_parked got=%0d exp=0", bus.parked); end
    checks++; if (bus.all_occupied !== 1'b0) begin failures++; $display("FAIL zero_all got=%b exp=0", bus.all_occupied); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL zero_ov got=%b exp=1", bus.out_valid); end
    bus.new_capacity = 8'b1000_0000;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.parked !== 3'd0) begin failures++; $display("FAIL hold_parked[%0d] got=%0d exp=0", i, bus.parked); end
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_ov[%0d] got=%b exp=0", i, bus.out_valid); end
      checks++; if ({bus.all_occupied, bus.saturated} !== 2'b00) begin failures++; $display("FAIL hold_flags[%0d] got=%b exp=00", i, {bus.all_occupied, bus.saturated}); end
    end
  endtask

  task automatic test_reset_priority();
    bus.new_capacity = 8'b0000_1111;
    bus.in_valid = 1'b1;
    step();
    checks++; if (bus.parked !== 3'd4) begin failures++; $display("FAIL pre_rst_parked got=%0d exp=4", bus.parked); end
    rst = 1'b1;
    bus.new_capacity = 8'hFF;
    step();
    checks++; if (bus.parked !== 3'd0) begin failures++; $display("FAIL rstpri_parked got=%0d exp=0", bus.parked); end
    checks++; if ({bus.all_occupied, bus.saturated} !== 2'b00) begin failures++; $display("FAIL rstpri_flags got=%b exp=00", {bus.all_occupied, bus.saturated}); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstpri_ov got=%b exp=0", bus.out_valid); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rstpri_stale_ov got=%b exp=0", bus.out_valid); end
    checks++; if (bus.parked !== 3'd0) begin failures++; $display("FAIL rstpri_after_parked got=%0d exp=0", bus.parked); end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic       vld;
    int         c;
    logic [2:0] exp_parked;
    logic       exp_all;
    logic       exp_sat;
    exp_parked = 3'd0;
    exp_all    = 1'b0;
    exp_sat    = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      v   = 8'($urandom_range(0, 255));
      vld = ($urandom_range(0, 3) != 0);
      bus.new_capacity = v;
      bus.in_valid = vld;
      step();
      if (vld) begin
        c = 0;
        for (int b = 0; b < 8; b++) c += int'(v[b]);
        exp_parked = (c > 7) ? 3'd7 : 3'(c);
        exp_sat    = (c > 7);
        exp_all    = (c == 8);
      end
      checks++;
      if ({bus.parked, bus.all_occupied, bus.saturated, bus.out_valid} !== {exp_parked, exp_all, exp_sat, vld}) begin
        failures++;
        $display("FAIL rand[%0d] vec=%h vld=%b got p=%0d a=%b s=%b ov=%b exp p=%0d a=%b s=%b ov=%b",
                 n, v, vld, bus.parked, bus.all_occupied, bus.saturated, bus.out_valid,
                 exp_parked, exp_all, exp_sat, vld);
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.new_capacity = 8'h00;
    test_reset();
    test_single();
    test_saturation();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ones_counter.md
Name: ones_counter

Overview:
Registered population counter for the parking subsystem. It takes an 8-bit occupancy vector (one bit per parking space, 1 = occupied) and reports how many spaces are occupied on a 3-bit count. Because a 3-bit count cannot represent 8, a separate full flag covers the all-occupied case. It sits between the space-sensor register and the capacity/display logic.

Parameters:
- N_SPACES, default 8: width of the occupancy vector; must be at least 2.
- CNT_W, default 3: width of the parked count output.
- Elaboration must fail if CNT_W < 1 or N_SPACES > 64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- new_capacity  input  N_SPACES  occupancy vector; bit i = space i occupied.
- in_valid  input  1  new_capacity is sampled on this edge when high.
- parked  output  CNT_W  number of set bits, saturated at 2^CNT_W-1.
- all_occupied  output  1  high when every bit of the sampled vector was 1.
- saturated  output  1  high when the true count exceeded 2^CNT_W-1.
- out_valid  output  1  one-cycle pulse marking new results.

Behaviour:
- Reset: on a rising edge with rst=1, parked=0, all_occupied=0, saturated=0, out_valid=0. rst has priority over in_valid.
- Sampling: on each rising edge with rst=0 and in_valid=1:
  - compute the true count C = number of 1 bits in new_capacity (range 0..N_SPACES), using an internal width of ceil(log2(N_SPACES+1)) bits (4 bits by default);
  - register parked = min(C, 2^CNT_W-1);
  - register saturated = (C > 2^CNT_W-1);
  - register all_occupied = (C == N_SPACES).
- Latency: exactly one clock. Results appear after the sampling edge and out_valid=1 for that one cycle.
- Hold: when in_valid=0, parked, all_occupied and saturated hold their last values, and out_valid=0 on the next edge.
- Back-to-back: in_valid held high gives a new result every cycle with no bubbles; out_valid stays high continuously.
- Defaults (N_SPACES=8, CNT_W=3): 8 occupied gives parked=7, saturated=1, all_occupied=1. 7 occupied gives parked=7, saturated=0, all_occupied=0.
- Count structure: adder tree of width-growing partial sums. The result is purely a function of the bit count and independent of bit position.
- Reset mid-stream: an edge with rst=1 discards the input sampled on that edge; no stale out_valid follows.
- X/Z on new_capacity is undefined; the bench drives only known values.

Test Plan:
1. Apply rst=1 for 2 cycles, then release -> parked=0, all_occupied=0, saturated=0, out_valid=0.
2. Drive new_capacity=8'b1111_0000 with in_valid=1 for one cycle -> next cycle parked=4, all_occupied=0, saturated=0, out_valid=1; the cycle after, out_valid=0 and parked still 4.
3. Drive 8'b1111_1111 -> parked=7, all_occupied=1, saturated=1. Then drive 8'b0111_1111 -> parked=7, all_occupied=0, saturated=0.
4. Stream back-to-back with in_valid=1: 8'b0000_0001, 8'b0001_0001, 8'b0011_0011, 8'b0101_1001, 8'b1010_1010 -> parked = 1, 2, 4, 4, 4 on consecutive cycles, with out_valid high throughout.
5. Drive 8'b0000_0000 -> parked=0, all_occupied=0. Then drive 8'b1000_0000 with in_valid=0 -> outputs unchanged and out_valid=0.
6. Assert rst together with in_valid=1 and new_capacity=8'hFF -> outputs are the reset values, with no out_valid pulse afterwards.
7. Random regression: for 1000 random vectors, check parked against a popcount reference model, including saturation and both flags.
